// File: rtl/serial_frame_tx_pkg.sv
// ============================================================================
// Module  : serial_frame_pkg
// Brief   : Shared types and helpers for the serial frame link (tx and rx).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_frame_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam logic FRAME_IDLE_LEVEL = 1'b1;

   // Words narrower than 16 bits are zero-extended, which leaves parity unchanged.
   function automatic logic even_parity(input logic [15:0] data);
      return ^data;
   endfunction

endpackage

`default_nettype wire

// File: rtl/serial_frame_tx_bit_timer.sv
// ============================================================================
// Module  : serial_bit_timer
// Brief   : Bit-period cycle counter; bit_tick marks the last cycle of a bit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_bit_timer
   import serial_frame_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic bit_tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;

   // With CLKS_PER_BIT=1 the counter sits at zero and every running cycle ticks.
   assign bit_tick = run && (cnt_q == c_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (!run || bit_tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/serial_frame_tx.sv
// ============================================================================
// Module  : serial_frame_tx
// Brief   : Parallel-to-serial frame transmitter (start, LSB-first data,
//           optional even parity when SERIAL_FRAME_TX_PARITY_EN, stop bits).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_frame_tx
   import serial_frame_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              tx,
   output logic              busy,
   output logic              done
);

   localparam int BIT_W = $clog2(DATA_W + 1);
   localparam logic [BIT_W-1:0] c_LAST_DATA = BIT_W'(DATA_W - 1);
   localparam logic [BIT_W-1:0] c_LAST_STOP = BIT_W'(STOP_BITS - 1);

   state_t              state_q;
   logic                tx_q;
   logic [DATA_W-1:0]   shift_q;
   logic [BIT_W-1:0]    bit_cnt_q;
   logic                w_bit_tick;
   logic [DATA_W-1:0]   w_shift_nxt;
`ifdef SERIAL_FRAME_TX_PARITY_EN
   logic                parity_q;
`endif

   serial_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk      (clk),
      .rst      (rst),
      .run      (state_q != IDLE),
      .bit_tick (w_bit_tick)
   );

   assign w_shift_nxt = shift_q >> 1;
   assign in_ready    = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign tx          = tx_q;
   assign done        = (state_q == STOP) && w_bit_tick && (bit_cnt_q == c_LAST_STOP);

   // tx_q is loaded one cycle ahead of each bit period so the line is fully registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         tx_q      <= FRAME_IDLE_LEVEL;
         shift_q   <= '0;
         bit_cnt_q <= '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  shift_q   <= in_data;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                  parity_q  <= even_parity(16'(in_data));
`endif
                  tx_q      <= 1'b0;
                  bit_cnt_q <= '0;
                  state_q   <= START;
               end
            end
            START: begin
               if (w_bit_tick) begin
                  tx_q    <= shift_q[0];
                  state_q <= DATA;
               end
            end
            DATA: begin
               if (w_bit_tick) begin
                  shift_q <= w_shift_nxt;
                  if (bit_cnt_q == c_LAST_DATA) begin
                     bit_cnt_q <= '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                     tx_q      <= parity_q;
                     state_q   <= PARITY;
`else
                     tx_q      <= FRAME_IDLE_LEVEL;
                     state_q   <= STOP;
`endif
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                     tx_q      <= w_shift_nxt[0];
                  end
               end
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            PARITY: begin
               if (w_bit_tick) begin
                  tx_q      <= FRAME_IDLE_LEVEL;
                  bit_cnt_q <= '0;
                  state_q   <= STOP;
               end
            end
`endif
            STOP: begin
               if (w_bit_tick) begin
                  if (bit_cnt_q == c_LAST_STOP) begin
                     state_q <= IDLE;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                  end
               end
            end
            default: begin
               tx_q    <= FRAME_IDLE_LEVEL;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
// ============================================================================
// Module  : tb_serial_frame_tx
// Brief   : Self-checking bench for serial_frame_tx against a frame-level model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_frame_tx;

   localparam int C_A = 4;
   localparam int S_A = 1;
   localparam int C_B = 1;
   localparam int S_B = 2;
`ifdef SERIAL_FRAME_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       va, vb;
   logic [7:0] da, db;
   logic       ra, rb, txa, txb, busya, busyb, donea, doneb;
   bit         cur_sel;
   logic       o_tx, o_ready, o_busy, o_done;

   int   n_err = 0;
   int   n_chk = 0;
   logic exp_bits[$];

   always #5 clk = ~clk;

   assign o_tx    = cur_sel ? txb   : txa;
   assign o_ready = cur_sel ? rb    : ra;
   assign o_busy  = cur_sel ? busyb : busya;
   assign o_done  = cur_sel ? doneb : donea;

   serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(C_A), .STOP_BITS(S_A)) dut_a (
      .clk(clk), .rst(rst), .in_valid(va), .in_ready(ra), .in_data(da),
      .tx(txa), .busy(busya), .done(donea)
   );

   serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(C_B), .STOP_BITS(S_B)) dut_b (
      .clk(clk), .rst(rst), .in_valid(vb), .in_ready(rb), .in_data(db),
      .tx(txb), .busy(busyb), .done(doneb)
   );

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Line bits of one frame in transmission order.
   task automatic build(input logic [7:0] w, input int stops);
      exp_bits.delete();
      exp_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_bits.push_back(w[i]);
      if (PAR == 1) exp_bits.push_back(^w);
      for (int i = 0; i < stops; i++) exp_bits.push_back(1'b1);
   endtask

   task automatic drive(input bit v, input logic [7:0] d);
      if (cur_sel) begin vb = v; db = d; end
      else         begin va = v; da = d; end
   endtask

   task automatic run_frame(input bit sel, input logic [7:0] w,
                            input bit keep_valid, input logic [7:0] nxt);
      int c, n, guard;
      cur_sel = sel;
      c = sel ? C_B : C_A;
      build(w, sel ? S_B : S_A);
      n = exp_bits.size() * c;
      #0;
      guard = 0;
      while (o_ready !== 1'b1 && guard < 200) begin
         tick();
         guard++;
      end
      chk_val("ready_before", o_ready, 1);
      drive(1'b1, w);
      tick();
      drive(keep_valid, nxt);
      for (int t = 1; t <= n; t++) begin
         chk_val($sformatf("tx@%0d", t), o_tx, exp_bits[(t-1)/c]);
         chk_val($sformatf("done@%0d", t), o_done, (t == n) ? 1 : 0);
         chk_val($sformatf("busy@%0d", t), o_busy, 1);
         chk_val($sformatf("ready@%0d", t), o_ready, 0);
         tick();
      end
      chk_val("tx_gap", o_tx, 1);
      chk_val("ready_after", o_ready, 1);
      chk_val("busy_after", o_busy, 0);
      chk_val("done_after", o_done, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] w;
      rst = 1'b1; va = 1'b0; vb = 1'b0; da = '0; db = '0; cur_sel = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_val("rst_tx", txa, 1);
      chk_val("rst_busy", busya, 0);
      chk_val("rst_done", donea, 0);
      rst = 1'b0;
      tick();
      chk_val("rst_ready", ra, 1);

      run_frame(0, 8'hA5, 0, 8'h00);
      run_frame(0, 8'h01, 0, 8'h00);
      run_frame(0, 8'h00, 1, 8'hFF);
      run_frame(0, 8'hFF, 0, 8'h00);

      for (int k = 0; k < 5; k++) begin
         repeat ($urandom_range(0, 3)) tick();
         w = 8'($urandom);
         run_frame(0, w, k[0], 8'($urandom));
         va = 1'b0;
      end

      // Abandon a frame mid-DATA with an asynchronous reset.
      tick();
      cur_sel = 1'b0;
      build(8'h3A, S_A);
      drive(1'b1, 8'h3A);
      tick();
      drive(1'b0, 8'h00);
      for (int t = 1; t <= 15; t++) begin
         chk_val($sformatf("pre_rst_tx@%0d", t), txa, exp_bits[(t-1)/C_A]);
         if (t < 15) tick();
      end
      rst = 1'b1;
      #1;
      chk_val("mid_rst_tx", txa, 1);
      chk_val("mid_rst_busy", busya, 0);
      chk_val("mid_rst_done", donea, 0);
      for (int t = 0; t < 3; t++) begin
         tick();
         chk_val("in_rst_done", donea, 0);
      end
      rst = 1'b0;
      tick();
      chk_val("post_rst_ready", ra, 1);
      chk_val("post_rst_tx", txa, 1);
      chk_val("post_rst_busy", busya, 0);

      run_frame(1, 8'h80, 0, 8'h00);
      for (int k = 0; k < 3; k++) begin
         w = 8'($urandom);
         run_frame(1, w, 1, 8'($urandom));
      end
      vb = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
Parallel-to-serial frame transmitter, the send side of the team's UART-style serial frame link.
- Accepts one DATA_W word per valid/ready handshake.
- Emits a frame on a single line: start bit (0), data LSB first, optional parity, STOP_BITS stop bits (1).
- Sits between a streaming source (FIFO/CPU register) and an off-chip pad.
- Pairs with the existing frame receiver on the far end.

Parameters:
DATA_W, 8, data bits per frame (1..16)
CLKS_PER_BIT, 16, clk cycles per serial bit (>=1)
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  source presents in_data
in_ready  output  1  block can accept a word; high only in IDLE
in_data  input  DATA_W  word to send; captured on handshake
tx  output  1  serial line; idles high
busy  output  1  frame in progress (any state except IDLE)
done  output  1  single-cycle pulse in the last cycle of the final stop bit

Behaviour:
- Reset (async assert, sync release):
  - tx=1, busy=0, done=0; state IDLE.
  - Bit counter and cycle counter cleared.
  - in_ready=1 once reset is released.
- Handshake:
  - Transfer occurs in the cycle where in_valid && in_ready.
  - in_data is latched into the shift register in that cycle.
  - in_ready is combinational (state==IDLE) and does not depend on in_valid.
  - in_data is don't-care outside the handshake cycle.
- States, each held for exactly CLKS_PER_BIT cycles per bit:
  - IDLE: tx=1. On transfer -> START.
  - START: tx=0 for one bit period -> DATA.
  - DATA: tx=shift[0], shifting right after each bit period. After DATA_W bits -> PARITY if the parity feature is compiled in, else -> STOP.
  - PARITY: tx=even parity (XOR of all data bits) for one bit period -> STOP.
  - STOP: tx=1 for STOP_BITS bit periods. done=1 in the final cycle of the final period, then -> IDLE.
- Timing:
  - Transfer in cycle T: tx falls at T+1.
  - Frame occupies T+1 .. T+N*CLKS_PER_BIT, where N = 1+DATA_W+STOP_BITS(+1 with parity).
  - done is asserted in cycle T+N*CLKS_PER_BIT.
  - IDLE and in_ready=1 in cycle T+N*CLKS_PER_BIT+1.
  - Minimum gap between frames is one idle cycle; the line stays high during it.
- Counters:
  - Cycle counter width $clog2(CLKS_PER_BIT) (minimum 1); wraps from CLKS_PER_BIT-1 to 0 at each bit boundary.
  - Bit counter width $clog2(DATA_W+1).
  - CLKS_PER_BIT=1 is legal: one bit per cycle, counter compare always true.
- tx is registered; no combinational path from inputs to tx.
- Reset mid-frame: tx returns high immediately (async), frame is abandoned, no done pulse, in_ready=1 after release.
- in_valid held high across a frame: no second capture until IDLE; the next word is accepted in the first IDLE cycle.

Optional Feature:
- Macro SERIAL_FRAME_TX_PARITY_EN.
- Defined: PARITY state present; an even-parity bit is inserted after the data bits and N increases by 1.
- Undefined: no PARITY state, no parity logic synthesized; STOP follows DATA directly.

Decomposition:
- Package serial_frame_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP), 3-bit logic;
  - constant FRAME_IDLE_LEVEL = 1'b1;
  - shared parity function even_parity(data) for reuse by the receiver.
- Sub-module serial_bit_timer: cycle counter with parameter CLKS_PER_BIT, inputs clk/rst/run, output bit_tick pulsed on the last cycle of each bit period. The receiver instantiates the same timer.

Test Plan:
- Single word, CLKS_PER_BIT=4, DATA_W=8, no parity, in_data=8'hA5 accepted at T:
  - tx bits 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, over T+1..T+40;
  - done=1 only at T+40; in_ready=1 at T+41.
- Parity build, same stimulus 8'hA5 (four ones): parity bit 0 occupies T+37..T+40, stop bit T+41..T+44, done at T+44. Repeat with 8'h01: parity bit 1.
- Back-to-back: in_valid held high with 8'h00 then 8'hFF:
  - second handshake exactly one cycle after done;
  - tx high for that single cycle;
  - in_ready low for the entire first frame.
- Reset mid-DATA (assert rst at T+15, release at T+18): tx=1 in the same cycle rst rises, busy=0, no done pulse, in_ready=1 at first edge after release.
- Boundary timing, CLKS_PER_BIT=1, STOP_BITS=2, in_data=8'h80: 11-cycle frame (0,0,0,0,0,0,0,0,1,1,1), done in the 11th cycle.
